// File: rtl/clock_keypad.sv
// Keypad front end for a clock: synchronized, debounced keys drive a RUN/SET_TIME/SET_DATE
// field-select FSM with +1/-1 step pulses. Define KEYPAD_AUTOREPEAT_EN to build up/down auto-repeat.
module clock_keypad #(
  parameter int DB_TICKS   = 20,
  parameter int RPT_DELAY  = 500,
  parameter int RPT_PERIOD = 100,
  parameter int IDLE_TICKS = 30000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       key_mode,
  input  logic       key_next,
  input  logic       key_up,
  input  logic       key_down,
  output logic [1:0] mode,
  output logic [5:0] select,
  output logic       button_inc,
  output logic       button_dec
);

  localparam int DW = $clog2(DB_TICKS + 1);
  localparam int IW = $clog2(IDLE_TICKS + 2);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_TIME = 2'b01,
    ST_SET_DATE = 2'b10
  } state_t;

  // key index: 0 mode, 1 next, 2 up, 3 down
  logic [3:0]    sync1_r, sync2_r, db_r, press_r;
  logic [DW-1:0] db_cnt_r [4];
  logic [IW-1:0] idle_r;
  state_t        st_r, st_nx_s;
  logic [5:0]    sel_r, sel_nx_s;
  logic          inc_r, dec_r, inc_nx_s, dec_nx_s;
  logic          mode_ev_s, next_ev_s, up_ev_s, dn_ev_s, in_set_s, timeout_s;
  logic          rpt_inc_s, rpt_dec_s;

  // Two-flop synchronizers for the raw buttons.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= {key_down, key_up, key_next, key_mode};
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a level after DB_TICKS consecutive disagreeing ticks; flag 0->1 as a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_r    <= 4'b0000;
      press_r <= 4'b0000;
      for (int i = 0; i < 4; i++) db_cnt_r[i] <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        press_r[i] <= 1'b0;
        if (tick) begin
          if (sync2_r[i] != db_r[i]) begin
            if (db_cnt_r[i] == DW'(DB_TICKS - 1)) begin
              db_r[i]     <= sync2_r[i];
              db_cnt_r[i] <= {DW{1'b0}};
              press_r[i]  <= sync2_r[i];
            end else begin
              db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
            end
          end else begin
            db_cnt_r[i] <= {DW{1'b0}};
          end
        end
      end
    end
  end

  // Event arbitration, next state/select and step pulse requests.
  always_comb begin
    mode_ev_s = press_r[0];
    next_ev_s = press_r[1] & ~press_r[0];
    up_ev_s   = press_r[2] & ~press_r[3];
    dn_ev_s   = press_r[3] & ~press_r[2];
    in_set_s  = (st_r != ST_RUN);
    timeout_s = (IDLE_TICKS != 0) && in_set_s && (idle_r >= IW'(IDLE_TICKS));
    st_nx_s   = st_r;
    sel_nx_s  = sel_r;
    if (mode_ev_s) begin
      case (st_r)
        ST_RUN: begin
          st_nx_s  = ST_SET_TIME;
          sel_nx_s = 6'b000001;
        end
        ST_SET_TIME: begin
          st_nx_s  = ST_SET_DATE;
          sel_nx_s = 6'b001000;
        end
        default: begin
          st_nx_s  = ST_RUN;
          sel_nx_s = 6'b000000;
        end
      endcase
    end else if (timeout_s) begin
      st_nx_s  = ST_RUN;
      sel_nx_s = 6'b000000;
    end else if (next_ev_s && in_set_s) begin
      // the inactive group is all zero, so rotating both groups only moves the live one
      sel_nx_s = {sel_r[4], sel_r[3], sel_r[5], sel_r[1], sel_r[0], sel_r[2]};
    end else begin
      sel_nx_s = sel_r;
    end
    inc_nx_s = (up_ev_s & in_set_s) | rpt_inc_s;
    dec_nx_s = (dn_ev_s & in_set_s) | rpt_dec_s;
  end

  // Registered FSM state and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_r  <= ST_RUN;
      sel_r <= 6'b000000;
      inc_r <= 1'b0;
      dec_r <= 1'b0;
    end else begin
      st_r  <= st_nx_s;
      sel_r <= sel_nx_s;
      inc_r <= inc_nx_s;
      dec_r <= dec_nx_s;
    end
  end

  // Idle timeout counter, only live in the SET states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_r <= {IW{1'b0}};
    end else if (!in_set_s || (|press_r)) begin
      idle_r <= {IW{1'b0}};
    end else if (tick && (idle_r < IW'(IDLE_TICKS))) begin
      idle_r <= idle_r + IW'(1);
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic          rpt_act_r, rpt_up_r, rpt_phase_r;
  logic [RW-1:0] rpt_cnt_r;
  logic [RW-1:0] rpt_lim_s;
  logic          rpt_held_s, rpt_fire_s;

  // Repeat fires while exactly the armed key is held and nothing cancels it this cycle.
  always_comb begin
    rpt_held_s = rpt_up_r ? (db_r[2] & ~db_r[3]) : (db_r[3] & ~db_r[2]);
    rpt_lim_s  = rpt_phase_r ? RW'(RPT_PERIOD - 1) : RW'(RPT_DELAY - 1);
    rpt_fire_s = rpt_act_r && rpt_held_s && in_set_s && !mode_ev_s && !timeout_s &&
                 tick && (rpt_cnt_r == rpt_lim_s);
    rpt_inc_s  = rpt_fire_s & rpt_up_r;
    rpt_dec_s  = rpt_fire_s & ~rpt_up_r;
  end

  // Repeat arming, cancellation and delay/period counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_act_r   <= 1'b0;
      rpt_up_r    <= 1'b0;
      rpt_phase_r <= 1'b0;
      rpt_cnt_r   <= {RW{1'b0}};
    end else if (mode_ev_s || timeout_s || !in_set_s) begin
      rpt_act_r <= 1'b0;
    end else if (up_ev_s || dn_ev_s) begin
      rpt_act_r   <= 1'b1;
      rpt_up_r    <= up_ev_s;
      rpt_phase_r <= 1'b0;
      rpt_cnt_r   <= {RW{1'b0}};
    end else if (rpt_act_r && !rpt_held_s) begin
      rpt_act_r <= 1'b0;
    end else if (rpt_act_r && tick) begin
      if (rpt_cnt_r == rpt_lim_s) begin
        rpt_cnt_r   <= {RW{1'b0}};
        rpt_phase_r <= 1'b1;
      end else begin
        rpt_cnt_r <= rpt_cnt_r + RW'(1);
      end
    end
  end
`else
  assign rpt_inc_s = 1'b0;
  assign rpt_dec_s = 1'b0;
`endif

  assign mode       = st_r;
  assign select     = sel_r;
  assign button_inc = inc_r;
  assign button_dec = dec_r;

endmodule
